// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the instruction/data memory arbiter.
package mem_arbiter_pkg;

  localparam int unsigned DEF_WORD_LEN = 32;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_CMD  = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } arb_owner_t;

endpackage

// File: rtl/mem_arb_priority.sv
// Fixed data-over-fetch priority with a starvation counter that forces a fetch
// grant after STARVE_LIMIT consecutive data grants taken while fetch waited.
module mem_arb_priority
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT   = 4,
  parameter int unsigned STARVE_CNT_BIT = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic i_req_valid,
  input  logic d_req_valid,
  input  logic idle,
  output logic grant_i,
  output logic grant_d
);

  localparam logic [STARVE_CNT_BIT-1:0] LIMIT = STARVE_CNT_BIT'(STARVE_LIMIT);

  logic [STARVE_CNT_BIT-1:0] r_starve_cnt;
  logic                      w_starved;

  assign w_starved = i_req_valid && (r_starve_cnt >= LIMIT);
  assign grant_d   = idle && d_req_valid && !w_starved;
  assign grant_i   = idle && i_req_valid && !grant_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve_cnt <= '0;
    end else if (grant_i) begin
      r_starve_cnt <= '0;
    end else if (grant_d && i_req_valid && (r_starve_cnt != '1)) begin
      r_starve_cnt <= r_starve_cnt + STARVE_CNT_BIT'(1);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between fetch and data requesters; one
// transaction outstanding, response routed back to the issuing requester.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned WORD_LEN       = DEF_WORD_LEN,
  parameter int unsigned STARVE_LIMIT   = 4,
  parameter int unsigned STARVE_CNT_BIT = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req_valid,
  output logic                i_req_ready,
  input  logic [WORD_LEN-1:0] i_addr,
  output logic                i_resp_valid,
  output logic [WORD_LEN-1:0] i_rdata,
  input  logic                d_req_valid,
  output logic                d_req_ready,
  input  logic [WORD_LEN-1:0] d_addr,
  input  logic                d_wen,
  input  logic [WORD_LEN-1:0] d_wdata,
  output logic                d_resp_valid,
  output logic [WORD_LEN-1:0] d_rdata,
  output logic                mem_cmd_valid,
  input  logic                mem_cmd_ready,
  output logic [WORD_LEN-1:0] mem_addr,
  output logic                mem_wen,
  output logic [WORD_LEN-1:0] mem_wdata,
  input  logic                mem_resp_valid,
  input  logic [WORD_LEN-1:0] mem_rdata,
  output logic                busy
);

  arb_state_t          r_state;
  arb_owner_t          r_owner;
  logic [WORD_LEN-1:0] r_addr;
  logic [WORD_LEN-1:0] r_wdata;
  logic [WORD_LEN-1:0] r_i_rdata;
  logic [WORD_LEN-1:0] r_d_rdata;
  logic                r_wen;
  logic                r_cmd_valid;
  logic                r_i_resp;
  logic                r_d_resp;

  logic w_idle;
  logic w_grant_i;
  logic w_grant_d;

  assign w_idle = (r_state == ARB_IDLE);

  mem_arb_priority #(
    .STARVE_LIMIT  (STARVE_LIMIT),
    .STARVE_CNT_BIT(STARVE_CNT_BIT)
  ) u_priority (
    .clk        (clk),
    .rst        (rst),
    .i_req_valid(i_req_valid),
    .d_req_valid(d_req_valid),
    .idle       (w_idle),
    .grant_i    (w_grant_i),
    .grant_d    (w_grant_d)
  );

  // Grants already include the IDLE and valid terms, so they double as ready.
  assign i_req_ready   = w_grant_i;
  assign d_req_ready   = w_grant_d;
  assign mem_cmd_valid = r_cmd_valid;
  assign mem_addr      = r_addr;
  assign mem_wen       = r_wen;
  assign mem_wdata     = r_wdata;
  assign i_resp_valid  = r_i_resp;
  assign d_resp_valid  = r_d_resp;
  assign i_rdata       = r_i_rdata;
  assign d_rdata       = r_d_rdata;
  assign busy          = !w_idle;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ARB_IDLE;
      r_owner     <= OWNER_I;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wen       <= 1'b0;
      r_cmd_valid <= 1'b0;
      r_i_rdata   <= '0;
      r_d_rdata   <= '0;
      r_i_resp    <= 1'b0;
      r_d_resp    <= 1'b0;
    end else begin
      r_i_resp <= 1'b0;
      r_d_resp <= 1'b0;
      unique case (r_state)
        ARB_IDLE: begin
          if (w_grant_i || w_grant_d) begin
            r_state     <= ARB_CMD;
            r_cmd_valid <= 1'b1;
            r_owner     <= w_grant_d ? OWNER_D : OWNER_I;
            r_addr      <= w_grant_d ? d_addr : i_addr;
            r_wen       <= w_grant_d && d_wen;
            r_wdata     <= w_grant_d ? d_wdata : '0;
          end
        end
        ARB_CMD: begin
          if (mem_cmd_ready) begin
            r_state     <= ARB_RESP;
            r_cmd_valid <= 1'b0;
          end
        end
        ARB_RESP: begin
          if (mem_resp_valid) begin
            r_state <= ARB_IDLE;
            if (r_owner == OWNER_D) begin
              r_d_rdata <= mem_rdata;
              r_d_resp  <= 1'b1;
            end else begin
              r_i_rdata <= mem_rdata;
              r_i_resp  <= 1'b1;
            end
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-level reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mem_arbiter;

  localparam int unsigned W     = 32;
  localparam int          LIMIT = 4;
  localparam int          CMAX  = 7;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_req_valid, i_req_ready, i_resp_valid;
  logic [W-1:0] i_addr, i_rdata;
  logic         d_req_valid, d_req_ready, d_wen, d_resp_valid;
  logic [W-1:0] d_addr, d_wdata, d_rdata;
  logic         mem_cmd_valid, mem_cmd_ready, mem_wen, mem_resp_valid;
  logic [W-1:0] mem_addr, mem_wdata, mem_rdata;
  logic         busy;

  always #5 clk = ~clk;

  mem_arbiter #(
    .WORD_LEN      (W),
    .STARVE_LIMIT  (LIMIT),
    .STARVE_CNT_BIT(3)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_req_valid   (i_req_valid),
    .i_req_ready   (i_req_ready),
    .i_addr        (i_addr),
    .i_resp_valid  (i_resp_valid),
    .i_rdata       (i_rdata),
    .d_req_valid   (d_req_valid),
    .d_req_ready   (d_req_ready),
    .d_addr        (d_addr),
    .d_wen         (d_wen),
    .d_wdata       (d_wdata),
    .d_resp_valid  (d_resp_valid),
    .d_rdata       (d_rdata),
    .mem_cmd_valid (mem_cmd_valid),
    .mem_cmd_ready (mem_cmd_ready),
    .mem_addr      (mem_addr),
    .mem_wen       (mem_wen),
    .mem_wdata     (mem_wdata),
    .mem_resp_valid(mem_resp_valid),
    .mem_rdata     (mem_rdata),
    .busy          (busy)
  );

  int checks   = 0;
  int failures = 0;

  // Model: one outstanding transaction record plus per-requester results.
  bit          m_out;
  bit          m_issued;
  bit          m_own_d;
  bit          m_wen;
  logic [31:0] m_addr, m_wdata, m_irdata, m_drdata;
  bit          m_ipulse, m_dpulse;
  int          m_starve;
  bit          grant_log[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_out = 0; m_issued = 0; m_own_d = 0; m_wen = 0;
    m_addr = '0; m_wdata = '0; m_irdata = '0; m_drdata = '0;
    m_ipulse = 0; m_dpulse = 0; m_starve = 0;
  endfunction

  task automatic idle_inputs();
    i_req_valid = 0; i_addr = '0;
    d_req_valid = 0; d_addr = '0; d_wen = 0; d_wdata = '0;
    mem_cmd_ready = 0; mem_resp_valid = 0; mem_rdata = '0;
  endtask

  // One clock: check request-side readies, advance model, check registered outputs.
  task automatic step();
    bit fetch_wins, acc_i, acc_d;
    #1;
    fetch_wins = !m_out && i_req_valid && (!d_req_valid || m_starve >= LIMIT);
    acc_i      = fetch_wins;
    acc_d      = !m_out && d_req_valid && !fetch_wins;
    chk("i_req_ready", i_req_ready, acc_i);
    chk("d_req_ready", d_req_ready, acc_d);
    if (!rst && (i_req_ready || d_req_ready)) grant_log.push_back(d_req_ready);

    m_ipulse = 0;
    m_dpulse = 0;
    if (rst) begin
      model_reset();
    end else if (!m_out) begin
      if (acc_i || acc_d) begin
        m_out    = 1;
        m_issued = 0;
        m_own_d  = acc_d;
        m_addr   = acc_d ? d_addr : i_addr;
        m_wen    = acc_d && d_wen;
        m_wdata  = acc_d ? d_wdata : 32'h0;
        if (acc_i) m_starve = 0;
        else if (i_req_valid) m_starve = (m_starve >= CMAX) ? CMAX : m_starve + 1;
      end
    end else if (!m_issued) begin
      if (mem_cmd_ready) m_issued = 1;
    end else if (mem_resp_valid) begin
      m_out = 0;
      if (m_own_d) begin m_drdata = mem_rdata; m_dpulse = 1; end
      else begin m_irdata = mem_rdata; m_ipulse = 1; end
    end

    @(posedge clk);
    #1;
    chk("busy", busy, m_out);
    chk("mem_cmd_valid", mem_cmd_valid, m_out && !m_issued);
    chk("mem_addr", mem_addr, m_addr);
    chk("mem_wen", mem_wen, m_wen);
    chk("mem_wdata", mem_wdata, m_wdata);
    chk("i_resp_valid", i_resp_valid, m_ipulse);
    chk("d_resp_valid", d_resp_valid, m_dpulse);
    chk("i_rdata", i_rdata, m_irdata);
    chk("d_rdata", d_rdata, m_drdata);
  endtask

  initial begin
    bit exp_pat[6];
    exp_pat = '{1, 1, 1, 1, 0, 1};

    rst = 1;
    idle_inputs();
    @(posedge clk);
    #1;
    model_reset();
    chk("rst_busy", busy, 0);
    chk("rst_cmd_valid", mem_cmd_valid, 0);
    chk("rst_i_rdata", i_rdata, 0);
    chk("rst_d_resp", d_resp_valid, 0);
    step();
    rst = 0;

    // Single fetch
    i_req_valid = 1; i_addr = 32'h8; mem_cmd_ready = 1;
    step();
    chk("f_cmd_valid", mem_cmd_valid, 1);
    chk("f_addr", mem_addr, 32'h8);
    chk("f_wen", mem_wen, 0);
    i_req_valid = 0;
    step();
    mem_resp_valid = 1; mem_rdata = 32'h00A00093;
    step();
    chk("f_pulse", i_resp_valid, 1);
    chk("f_rdata", i_rdata, 32'h00A00093);
    chk("f_no_d_pulse", d_resp_valid, 0);
    mem_resp_valid = 0;
    step();
    chk("f_pulse_once", i_resp_valid, 0);

    // Store
    d_req_valid = 1; d_addr = 32'h100; d_wen = 1; d_wdata = 32'hDEADBEEF;
    step();
    chk("s_wen", mem_wen, 1);
    chk("s_wdata", mem_wdata, 32'hDEADBEEF);
    d_req_valid = 0;
    step();
    mem_resp_valid = 1; mem_rdata = 32'h0;
    step();
    chk("s_pulse", d_resp_valid, 1);
    chk("s_idle", busy, 0);
    mem_resp_valid = 0;

    // Simultaneous requests: data first, then fetch
    i_req_valid = 1; i_addr = 32'h4; d_req_valid = 1; d_addr = 32'h20; d_wen = 0;
    #1;
    chk("sim_d_ready", d_req_ready, 1);
    chk("sim_i_ready", i_req_ready, 0);
    step();
    chk("sim_d_addr", mem_addr, 32'h20);
    d_req_valid = 0;
    step();
    mem_resp_valid = 1; mem_rdata = 32'h11112222;
    step();
    chk("sim_d_rdata", d_rdata, 32'h11112222);
    mem_resp_valid = 0;
    step();
    chk("sim_i_addr", mem_addr, 32'h4);
    i_req_valid = 0;
    step();
    mem_resp_valid = 1; mem_rdata = 32'h33334444;
    step();
    chk("sim_i_rdata", i_rdata, 32'h33334444);
    mem_resp_valid = 0;

    // Starvation: both valid continuously, memory always ready/responding
    grant_log.delete();
    i_req_valid = 1; i_addr = 32'h40; d_req_valid = 1; d_addr = 32'h80; d_wen = 0;
    mem_cmd_ready = 1; mem_resp_valid = 1; mem_rdata = 32'h5;
    for (int k = 0; k < 18; k++) step();
    i_req_valid = 0; d_req_valid = 0; mem_resp_valid = 0;
    chk("starve_grants", grant_log.size(), 6);
    for (int k = 0; k < 6 && k < grant_log.size(); k++)
      chk("starve_order", grant_log[k], exp_pat[k]);

    // Backpressure on the command channel
    d_req_valid = 1; d_addr = 32'h40; d_wen = 1; d_wdata = 32'h12345678; mem_cmd_ready = 0;
    step();
    i_req_valid = 1; d_addr = 32'h44; d_wdata = 32'h0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp_cmd_valid", mem_cmd_valid, 1);
      chk("bp_addr", mem_addr, 32'h40);
      chk("bp_wdata", mem_wdata, 32'h12345678);
      chk("bp_readies", {i_req_ready, d_req_ready}, 0);
    end
    i_req_valid = 0; d_req_valid = 0; mem_cmd_ready = 1;
    step();
    mem_resp_valid = 1;
    step();
    chk("bp_done", d_resp_valid, 1);
    mem_resp_valid = 0;

    // Reset while waiting for the response, then a late response
    i_req_valid = 1; i_addr = 32'h30;
    step();
    i_req_valid = 0;
    step();
    rst = 1;
    step();
    chk("rr_busy", busy, 0);
    rst = 0; mem_resp_valid = 1; mem_rdata = 32'hBAD0BAD0;
    step();
    chk("rr_no_i_pulse", i_resp_valid, 0);
    chk("rr_no_d_pulse", d_resp_valid, 0);
    chk("rr_idle", busy, 0);
    mem_resp_valid = 0;
    i_req_valid = 1; i_addr = 32'h34;
    step();
    i_req_valid = 0;
    step();
    mem_resp_valid = 1; mem_rdata = 32'hCAFE0001;
    step();
    chk("rr_after_pulse", i_resp_valid, 1);
    chk("rr_after_rdata", i_rdata, 32'hCAFE0001);
    mem_resp_valid = 0;

    // Randomized traffic, including spurious responses and occasional reset
    for (int n = 0; n < 3000; n++) begin
      rst            = ($urandom_range(63) == 0);
      i_req_valid    = $urandom_range(1);
      i_addr         = $urandom;
      d_req_valid    = $urandom_range(1);
      d_addr         = $urandom;
      d_wen          = $urandom_range(1);
      d_wdata        = $urandom;
      mem_cmd_ready  = ($urandom_range(3) != 0);
      mem_resp_valid = ($urandom_range(4) < 2);
      mem_rdata      = $urandom;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
